cruise_speed_regulator: RTL and testbench



---
 rtl/cruise_speed_regulator_pkg.sv | 39 +++
 rtl/cruise_speed_regulator_trend_filter.sv | 42 ++++
 rtl/cruise_speed_regulator.sv | 140 ++++++++++++++
 tb/tb_cruise_speed_regulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cruise_speed_regulator_pkg.sv
// Shared definitions for the cruise speed path: state encoding, speed width,
// default speed limits and the saturating target-step helpers.
package cruise_speed_regulator_pkg;

   localparam int SPEED_W = 8;

   localparam int DEF_MIN_SPEED = 40;
   localparam int DEF_MAX_SPEED = 200;
   localparam int DEF_STEP      = 5;
   localparam int DEF_HOLD      = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_CRUISE    = 2'b01,
      ST_SUSPENDED = 2'b10
   } cruise_state_e;

   // Sum is formed one bit wider so a target near 255 cannot wrap.
   function automatic logic [SPEED_W-1:0] step_up(
      input logic [SPEED_W-1:0] cur,
      input logic [SPEED_W-1:0] step,
      input logic [SPEED_W-1:0] max_v
   );
      logic [SPEED_W:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      return (sum > {1'b0, max_v}) ? max_v : sum[SPEED_W-1:0];
   endfunction

   function automatic logic [SPEED_W-1:0] step_down(
      input logic [SPEED_W-1:0] cur,
      input logic [SPEED_W-1:0] step,
      input logic [SPEED_W-1:0] min_v
   );
      logic [SPEED_W:0] floor_plus_step;
      floor_plus_step = {1'b0, min_v} + {1'b0, step};
      return ({1'b0, cur} < floor_plus_step) ? min_v : cur - step;
   endfunction

endpackage

// File: rtl/cruise_speed_regulator_trend_filter.sv
// Saturating consecutive-cycle counter; the request asserts the cycle after
// the count has sat at HOLD while the qualifier is still present.
module cruise_speed_regulator_trend_filter
   import cruise_speed_regulator_pkg::*;
#(
   parameter int HOLD = DEF_HOLD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic qualify,
   output logic req
);

   localparam int CW = 4;
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;

   always_comb begin
      cnt_d = '0;
      req_d = 1'b0;
      if (qualify) begin
         req_d = (cnt_q == HOLD_C);
         cnt_d = req_d ? cnt_q : cnt_q + ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         req_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         req_q <= req_d;
      end
   end

   assign req = req_q;

endmodule

// File: rtl/cruise_speed_regulator.sv
// Driver-facing cruise state machine and target register; consumes the
// external comparator result and filters it into throttle up/down requests.
module cruise_speed_regulator
   import cruise_speed_regulator_pkg::*;
#(
   parameter int MIN_SPEED = DEF_MIN_SPEED,
   parameter int MAX_SPEED = DEF_MAX_SPEED,
   parameter int STEP      = DEF_STEP,
   parameter int HOLD      = DEF_HOLD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SPEED_W-1:0] speed,
   input  logic               set_btn,
   input  logic               resume_btn,
   input  logic               cancel_btn,
   input  logic               inc_btn,
   input  logic               dec_btn,
   input  logic               brake,
   input  logic               accel_pedal,
   input  logic               cmp_g,
   input  logic               cmp_eq,
   input  logic               cmp_l,
   output logic [SPEED_W-1:0] target,
   output logic               cmp_en,
   output logic               active,
   output logic               throttle_up,
   output logic               throttle_down,
   output logic               cmp_fault,
   output logic [1:0]         state
);

   localparam logic [SPEED_W-1:0] MIN_C  = SPEED_W'(MIN_SPEED);
   localparam logic [SPEED_W-1:0] MAX_C  = SPEED_W'(MAX_SPEED);
   localparam logic [SPEED_W-1:0] STEP_C = SPEED_W'(STEP);

   logic set_q, resume_q, cancel_q, inc_q, dec_q;
   logic set_e, resume_e, cancel_e, inc_e, dec_e;

   cruise_state_e      state_q, state_d;
   logic [SPEED_W-1:0] target_q, target_d;
   logic               active_q, active_d;
   logic               fault_q, fault_d;

   logic cmp_legal, speed_ok, hold_ok, up_qual, dn_qual;

   always_comb begin
      set_e    = set_btn    & ~set_q;
      resume_e = resume_btn & ~resume_q;
      cancel_e = cancel_btn & ~cancel_q;
      inc_e    = inc_btn    & ~inc_q;
      dec_e    = dec_btn    & ~dec_q;

      cmp_legal = ( cmp_g & ~cmp_eq & ~cmp_l) |
                  (~cmp_g &  cmp_eq & ~cmp_l) |
                  (~cmp_g & ~cmp_eq &  cmp_l);
      speed_ok  = (speed >= MIN_C);

      state_d  = state_q;
      target_d = target_q;

      // Priority chain: only the highest-priority event in a cycle acts.
      if (brake) begin
         if (state_q == ST_CRUISE) state_d = ST_SUSPENDED;
      end else if (cancel_e) begin
         if (state_q == ST_CRUISE) begin
            state_d = ST_SUSPENDED;
         end else if (state_q == ST_SUSPENDED) begin
            state_d  = ST_IDLE;
            target_d = '0;
         end
      end else if ((state_q == ST_CRUISE) && !speed_ok) begin
         state_d = ST_SUSPENDED;
      end else if (set_e) begin
         if (speed_ok) begin
            state_d  = ST_CRUISE;
            target_d = speed;
         end
      end else if (resume_e) begin
         if ((state_q == ST_SUSPENDED) && speed_ok) state_d = ST_CRUISE;
      end else if ((state_q == ST_CRUISE) && (inc_e ^ dec_e)) begin
         target_d = inc_e ? step_up(target_q, STEP_C, MAX_C)
                          : step_down(target_q, STEP_C, MIN_C);
      end

      // A target change or leaving cruise restarts the trend filters.
      hold_ok = (state_q == ST_CRUISE) && (state_d == ST_CRUISE) &&
                (target_d == target_q) && !accel_pedal && cmp_legal;
      up_qual = hold_ok & cmp_l;
      dn_qual = hold_ok & cmp_g;

      fault_d  = active_q & ~cmp_legal;
      active_d = (state_d == ST_CRUISE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_q    <= 1'b1;
         resume_q <= 1'b1;
         cancel_q <= 1'b1;
         inc_q    <= 1'b1;
         dec_q    <= 1'b1;
         state_q  <= ST_IDLE;
         target_q <= '0;
         active_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         set_q    <= set_btn;
         resume_q <= resume_btn;
         cancel_q <= cancel_btn;
         inc_q    <= inc_btn;
         dec_q    <= dec_btn;
         state_q  <= state_d;
         target_q <= target_d;
         active_q <= active_d;
         fault_q  <= fault_d;
      end
   end

   cruise_speed_regulator_trend_filter #(.HOLD(HOLD)) u_trend_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .qualify (up_qual),
      .req     (throttle_up)
   );

   cruise_speed_regulator_trend_filter #(.HOLD(HOLD)) u_trend_down (
      .clk     (clk),
      .rst_n   (rst_n),
      .qualify (dn_qual),
      .req     (throttle_down)
   );

   assign target    = target_q;
   assign active    = active_q;
   assign cmp_en    = active_q;
   assign cmp_fault = fault_q;
   assign state     = state_q;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Directed bench for cruise_speed_regulator with a run-length behavioural
// model checked every cycle plus literal expectations at key points.
module tb_cruise_speed_regulator;

   localparam int MIN  = 40;
   localparam int MAX  = 200;
   localparam int STEP = 5;
   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] speed = 8'd0;
   logic       set_btn = 1'b0, resume_btn = 1'b0, cancel_btn = 1'b0;
   logic       inc_btn = 1'b0, dec_btn = 1'b0;
   logic       brake = 1'b0, accel_pedal = 1'b0;
   logic       cmp_g = 1'b0, cmp_eq = 1'b0, cmp_l = 1'b0;

   logic [7:0] target;
   logic       cmp_en, active, throttle_up, throttle_down, cmp_fault;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cruise_speed_regulator #(
      .MIN_SPEED(MIN), .MAX_SPEED(MAX), .STEP(STEP), .HOLD(HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .speed(speed),
      .set_btn(set_btn), .resume_btn(resume_btn), .cancel_btn(cancel_btn),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .brake(brake),
      .accel_pedal(accel_pedal), .cmp_g(cmp_g), .cmp_eq(cmp_eq), .cmp_l(cmp_l),
      .target(target), .cmp_en(cmp_en), .active(active),
      .throttle_up(throttle_up), .throttle_down(throttle_down),
      .cmp_fault(cmp_fault), .state(state)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: state/target from the event rules, throttle from
   // the length of the current run of qualifying cycles.
   int m_state, m_target, run_up, run_dn;
   int ns, nt, ncmp;
   bit m_up, m_dn, m_fault;
   bit p_set, p_res, p_can, p_inc, p_dec;
   bit e_set, e_res, e_can, e_inc, e_dec, legal, steady;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_target = 0; run_up = 0; run_dn = 0;
         m_up = 0; m_dn = 0; m_fault = 0;
         p_set = 1; p_res = 1; p_can = 1; p_inc = 1; p_dec = 1;
      end else begin
         e_set = set_btn && !p_set;
         e_res = resume_btn && !p_res;
         e_can = cancel_btn && !p_can;
         e_inc = inc_btn && !p_inc;
         e_dec = dec_btn && !p_dec;
         ncmp  = int'(cmp_g) + int'(cmp_eq) + int'(cmp_l);
         legal = (ncmp == 1);
         ns = m_state;
         nt = m_target;
         if (brake) begin
            if (m_state == 1) ns = 2;
         end else if (e_can) begin
            if (m_state == 1) ns = 2;
            else if (m_state == 2) begin ns = 0; nt = 0; end
         end else if (m_state == 1 && int'(speed) < MIN) begin
            ns = 2;
         end else if (e_set) begin
            if (int'(speed) >= MIN) begin ns = 1; nt = int'(speed); end
         end else if (e_res) begin
            if (m_state == 2 && int'(speed) >= MIN) ns = 1;
         end else if (m_state == 1 && e_inc && !e_dec) begin
            nt = (m_target + STEP > MAX) ? MAX : m_target + STEP;
         end else if (m_state == 1 && e_dec && !e_inc) begin
            nt = (m_target - STEP < MIN) ? MIN : m_target - STEP;
         end
         steady = (m_state == 1) && (ns == 1) && (nt == m_target) && !accel_pedal && legal;
         run_up = (steady && cmp_l) ? run_up + 1 : 0;
         run_dn = (steady && cmp_g) ? run_dn + 1 : 0;
         m_up = (run_up > HOLD);
         m_dn = (run_dn > HOLD);
         m_fault = (m_state == 1) && !legal;
         m_state = ns;
         m_target = nt;
         p_set = set_btn; p_res = resume_btn; p_can = cancel_btn;
         p_inc = inc_btn; p_dec = dec_btn;
      end
   end

   always @(negedge clk) begin
      chk("state", int'(state), m_state);
      chk("target", int'(target), m_target);
      chk("active", int'(active), int'(m_state == 1));
      chk("cmp_en", int'(cmp_en), int'(m_state == 1));
      chk("throttle_up", int'(throttle_up), int'(m_up));
      chk("throttle_down", int'(throttle_down), int'(m_dn));
      chk("cmp_fault", int'(cmp_fault), int'(m_fault));
      chk("throttle_exclusive", int'(throttle_up & throttle_down), 0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // 0 set, 1 resume, 2 cancel, 3 inc, 4 dec
   task automatic press(input int which);
      case (which)
         0: set_btn = 1'b1;
         1: resume_btn = 1'b1;
         2: cancel_btn = 1'b1;
         3: inc_btn = 1'b1;
         default: dec_btn = 1'b1;
      endcase
      tick(1);
      set_btn = 1'b0; resume_btn = 1'b0; cancel_btn = 1'b0;
      inc_btn = 1'b0; dec_btn = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(3);
      chk("reset_state", int'(state), 0);
      chk("reset_target", int'(target), 0);
      chk("reset_throttle", int'(throttle_up | throttle_down | cmp_fault), 0);

      // Engage at 60, then hold speed-below-target
      rst_n = 1'b1; cmp_eq = 1'b1; speed = 8'd60;
      tick(1);
      press(0);
      chk("engage_state", int'(state), 1);
      chk("engage_target", int'(target), 60);
      chk("model_target_pin", m_target, 60);
      cmp_eq = 1'b0; cmp_l = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk("up_latency", int'(throttle_up), int'(i == 5));
      end
      chk("up_no_down", int'(throttle_down), 0);

      // Increment saturation and decrement floor
      cmp_l = 1'b0; cmp_eq = 1'b1; speed = 8'd198;
      press(0);
      chk("set_198", int'(target), 198);
      press(3);
      chk("inc_sat_1", int'(target), 200);
      press(3);
      chk("inc_sat_2", int'(target), 200);
      speed = 8'd42;
      press(0);
      chk("set_42", int'(target), 42);
      press(4);
      chk("dec_floor_1", int'(target), 40);
      press(4);
      chk("dec_floor_2", int'(target), 40);
      chk("model_floor_pin", m_target, 40);

      // Brake, resume, cancel twice
      speed = 8'd60;
      press(0);
      cmp_eq = 1'b0; cmp_l = 1'b1;
      tick(6);
      chk("up_before_brake", int'(throttle_up), 1);
      brake = 1'b1;
      tick(1);
      chk("brake_state", int'(state), 2);
      chk("brake_target", int'(target), 60);
      chk("brake_throttle", int'(throttle_up), 0);
      brake = 1'b0; cmp_l = 1'b0; cmp_eq = 1'b1;
      tick(1);
      speed = 8'd55;
      press(1);
      chk("resume_state", int'(state), 1);
      chk("resume_target", int'(target), 60);
      press(2);
      chk("cancel1_state", int'(state), 2);
      press(2);
      chk("cancel2_state", int'(state), 0);
      chk("cancel2_target", int'(target), 0);

      // Down filter restarts after an equal cycle
      speed = 8'd80;
      press(0);
      cmp_eq = 1'b0; cmp_g = 1'b1;
      tick(3);
      cmp_g = 1'b0; cmp_eq = 1'b1;
      tick(1);
      chk("eq_clears_down", int'(throttle_down), 0);
      cmp_eq = 1'b0; cmp_g = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk("down_restart", int'(throttle_down), int'(i == 5));
      end

      // Illegal comparator codes
      cmp_l = 1'b1;
      tick(1);
      chk("fault_gl", int'(cmp_fault), 1);
      chk("fault_gl_down", int'(throttle_down), 0);
      chk("fault_gl_state", int'(state), 1);
      cmp_g = 1'b0; cmp_l = 1'b0;
      tick(1);
      chk("fault_none", int'(cmp_fault), 1);
      cmp_eq = 1'b1;
      tick(1);
      chk("fault_clear", int'(cmp_fault), 0);

      // Accelerator override, then low-speed suspend
      cmp_eq = 1'b0; cmp_l = 1'b1;
      tick(5);
      chk("up_before_accel", int'(throttle_up), 1);
      accel_pedal = 1'b1;
      tick(1);
      chk("accel_up", int'(throttle_up), 0);
      chk("accel_state", int'(state), 1);
      accel_pedal = 1'b0; cmp_l = 1'b0; cmp_eq = 1'b1;
      tick(1);
      speed = 8'd30;
      tick(1);
      chk("low_speed_suspend", int'(state), 2);
      speed = 8'd80;

      // Async reset mid-operation and button held through reset release
      press(0);
      chk("reengage", int'(state), 1);
      set_btn = 1'b1; rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_target", int'(target), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("held_set_ignored", int'(state), 0);
      set_btn = 1'b0;
      tick(1);
      press(0);
      chk("set_after_release", int'(state), 1);
      chk("set_after_release_tgt", int'(target), 80);
      press(2);
      press(2);
      speed = 8'd30;
      press(0);
      chk("set_too_slow", int'(state), 0);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
